// File: rtl/multicycle_chunk_adder_pkg.sv
// Shared types and helpers for the multicycle chunk adder.
// Holds the FSM state encoding and the slice-count / counter-width helpers.
package multicycle_chunk_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Number of CHUNK-wide slices in a WIDTH-bit operand.
    function automatic int chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Slice counter width; at least one bit even for a single slice.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multicycle_chunk_adder_if.sv
// Request/result bundle of the multicycle chunk adder.
// master drives start/a/b/carry_in/sub; slave returns busy/done/sum/carry_out/overflow.
interface multicycle_chunk_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    modport master (
        output start, a, b, carry_in, sub,
        input  busy, done, sum, carry_out, overflow
    );

    modport slave (
        input  start, a, b, carry_in, sub,
        output busy, done, sum, carry_out, overflow
    );
endinterface

// File: rtl/multicycle_chunk_adder_chunk_adder.sv
// Combinational CHUNK-bit adder slice.
// Ports: x, y, cin in; s, cout, and c_msb_in (carry into the top bit) out.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);
    always_comb begin
        {cout, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
        // Sum bit = x ^ y ^ carry-in, so the carry into the MSB falls out.
        c_msb_in  = s[CHUNK-1] ^ x[CHUNK-1] ^ y[CHUNK-1];
    end
endmodule

// File: rtl/multicycle_chunk_adder.sv
// WIDTH-bit add/subtract done one CHUNK slice per clock with a registered carry.
// Ports: clk, reset (sync, active-high), bus (slave: start/a/b/carry_in/sub -> busy/done/sum/carry_out/overflow).
module multicycle_chunk_adder
    import multicycle_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_chunk_adder_if.slave bus
);
    localparam int N  = chunks(WIDTH, CHUNK);
    localparam int CW = cnt_w(N);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cy_q, cy_d;
    logic             co_q, co_d;
    logic             ov_q, ov_d;

    logic [CHUNK-1:0] s;
    logic             cout;
    logic             c_msb_in;
    logic             last;
    logic [WIDTH-1:0] res_shift;

    // Operands shift right each RUN cycle so slice k always sits at bit 0.
    chunk_adder #(.CHUNK(CHUNK)) u_add (
        .x        (a_q[CHUNK-1:0]),
        .y        (b_q[CHUNK-1:0]),
        .cin      (cy_q),
        .s        (s),
        .cout     (cout),
        .c_msb_in (c_msb_in)
    );

    assign last = (cnt_q == CW'(N - 1));

    // Result fills from the top; after N shifts slice 0 lands at bit 0.
    assign res_shift = (res_q >> CHUNK) | (WIDTH'(s) << (WIDTH - CHUNK));

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_RUN;
            ST_RUN:  if (last)      state_d = ST_DONE;
            ST_DONE:                state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.busy      = (state_q == ST_RUN);
        bus.done      = (state_q == ST_DONE);
        bus.sum       = sum_q;
        bus.carry_out = co_q;
        bus.overflow  = ov_q;
    end

    // Datapath next-state
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        res_d = res_q;
        sum_d = sum_q;
        cnt_d = cnt_q;
        cy_d  = cy_q;
        co_d  = co_q;
        ov_d  = ov_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    // Subtract as A + ~B + ~borrow.
                    a_d   = bus.a;
                    b_d   = bus.sub ? ~bus.b : bus.b;
                    cy_d  = bus.sub ^ bus.carry_in;
                    cnt_d = '0;
                    res_d = '0;
                end
            end
            ST_RUN: begin
                a_d   = a_q >> CHUNK;
                b_d   = b_q >> CHUNK;
                res_d = res_shift;
                cy_d  = cout;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    sum_d = res_shift;
                    co_d  = cout;
                    ov_d  = cout ^ c_msb_in;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            sum_q <= '0;
            cnt_q <= '0;
            cy_q  <= 1'b0;
            co_q  <= 1'b0;
            ov_q  <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            res_q <= res_d;
            sum_q <= sum_d;
            cnt_q <= cnt_d;
            cy_q  <= cy_d;
            co_q  <= co_d;
            ov_q  <= ov_d;
        end
    end
endmodule

// File: tb/tb_multicycle_chunk_adder.sv
// Self-checking bench for multicycle_chunk_adder.
// Directed and random 8/4 operations, then a 16-bit sweep over CHUNK = 1, 4, 16.
module tb_multicycle_chunk_adder;

    logic clk = 1'b0;
    logic rst8;
    logic rst16;
    bit   sweep_go = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Golden model: plain integer arithmetic on the operand values.
    function automatic void ref_op(
        input  int     w,
        input  longint a,
        input  longint b,
        input  int     cin,
        input  int     sub,
        output longint s,
        output int     co,
        output int     ov
    );
        longint m, sa, sb, r, sr;
        m  = longint'(1) << w;
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        if (sub == 0) begin
            r  = a + b + cin;
            sr = sa + sb + cin;
            co = (r >= m) ? 1 : 0;
        end else begin
            r  = a - b - cin;
            sr = sa - sb - cin;
            co = (r >= 0) ? 1 : 0;
        end
        s  = ((r % m) + m) % m;
        ov = (sr < -(m / 2) || sr >= m / 2) ? 1 : 0;
    endfunction

    // ---------------- 8-bit, CHUNK=4 instance ----------------
    multicycle_chunk_adder_if #(.WIDTH(8)) bus8 ();

    multicycle_chunk_adder #(.WIDTH(8), .CHUNK(4)) dut8 (
        .clk   (clk),
        .reset (rst8),
        .bus   (bus8.slave)
    );

    task automatic run8(
        input string    nm,
        input logic [7:0] a,
        input logic [7:0] b,
        input logic     cin,
        input logic     sub,
        input bit       mid_start
    );
        longint     es;
        int         eco, eov, lat, glitch;
        logic [7:0] prev;
        ref_op(8, a, b, cin, sub, es, eco, eov);
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a = a;
        bus8.b = b;
        bus8.carry_in = cin;
        bus8.sub = sub;
        @(negedge clk);
        // Hold start high through RUN with junk operands when mid_start.
        bus8.start = mid_start;
        bus8.a = 8'($urandom);
        bus8.b = 8'($urandom);
        bus8.carry_in = 1'($urandom);
        bus8.sub = 1'($urandom);
        prev = bus8.sum;
        lat = 0;
        glitch = 0;
        while (bus8.busy && lat < 40) begin
            lat++;
            if (bus8.sum !== prev) glitch++;
            @(negedge clk);
        end
        bus8.start = 1'b0;
        chk({nm, " busy_cycles"}, lat, 2);
        chk({nm, " sum_stable"}, glitch, 0);
        chk({nm, " done"}, bus8.done, 1);
        chk({nm, " sum"}, bus8.sum, es);
        chk({nm, " carry_out"}, bus8.carry_out, eco);
        chk({nm, " overflow"}, bus8.overflow, eov);
        @(negedge clk);
        chk({nm, " done_pulse"}, bus8.done, 0);
    endtask

    // ---------------- 16-bit sweep instances ----------------
    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int CH = (g == 0) ? 1 : ((g == 1) ? 4 : 16);

        multicycle_chunk_adder_if #(.WIDTH(16)) bus ();

        multicycle_chunk_adder #(.WIDTH(16), .CHUNK(CH)) dut (
            .clk   (clk),
            .reset (rst16),
            .bus   (bus.slave)
        );

        bit fin = 1'b0;

        initial begin
            logic [15:0] a, b;
            logic        cin, sub;
            longint      es;
            int          eco, eov, lat;
            string       t;
            bus.start = 1'b0;
            bus.a = '0;
            bus.b = '0;
            bus.carry_in = 1'b0;
            bus.sub = 1'b0;
            t = $sformatf("w16c%0d", CH);
            wait (sweep_go);
            for (int i = 0; i < 1000; i++) begin
                a   = 16'($urandom);
                b   = 16'($urandom);
                cin = 1'($urandom);
                sub = 1'($urandom);
                ref_op(16, a, b, cin, sub, es, eco, eov);
                @(negedge clk);
                bus.start = 1'b1;
                bus.a = a;
                bus.b = b;
                bus.carry_in = cin;
                bus.sub = sub;
                @(negedge clk);
                bus.start = 1'b0;
                bus.a = 16'($urandom);
                bus.b = 16'($urandom);
                lat = 0;
                while (bus.busy && lat < 40) begin
                    lat++;
                    @(negedge clk);
                end
                chk({t, " latency"}, lat, 16 / CH);
                chk({t, " done"}, bus.done, 1);
                chk({t, " sum"}, bus.sum, es);
                chk({t, " carry_out"}, bus.carry_out, eco);
                chk({t, " overflow"}, bus.overflow, eov);
            end
            fin = 1'b1;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int dn, bz;
        rst8 = 1'b1;
        rst16 = 1'b1;
        bus8.start = 1'b0;
        bus8.a = '0;
        bus8.b = '0;
        bus8.carry_in = 1'b0;
        bus8.sub = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst busy", bus8.busy, 0);
        chk("rst done", bus8.done, 0);
        chk("rst sum", bus8.sum, 0);
        chk("rst carry_out", bus8.carry_out, 0);
        chk("rst overflow", bus8.overflow, 0);
        rst8 = 1'b0;
        rst16 = 1'b0;

        dn = 0;
        bz = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus8.done) dn++;
            if (bus8.busy) bz++;
        end
        chk("idle done_cnt", dn, 0);
        chk("idle busy_cnt", bz, 0);

        run8("add250", 8'd250, 8'd250, 1'b0, 1'b0, 1'b0);
        run8("add128c", 8'd128, 8'd128, 1'b1, 1'b0, 1'b0);
        run8("add127", 8'd127, 8'd1, 1'b0, 1'b0, 1'b0);
        run8("sub40", 8'd40, 8'd6, 1'b0, 1'b1, 1'b0);
        run8("midstart", 8'd17, 8'd99, 1'b1, 1'b0, 1'b1);
        run8("sub0", 8'd0, 8'd1, 1'b0, 1'b1, 1'b0);

        // Abort in the first RUN cycle; prior outputs are nonzero.
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a = 8'd100;
        bus8.b = 8'd50;
        bus8.carry_in = 1'b0;
        bus8.sub = 1'b0;
        @(negedge clk);
        bus8.start = 1'b0;
        chk("abort in_run", bus8.busy, 1);
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        dn = 0;
        bz = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus8.done) dn++;
            if (bus8.busy) bz++;
        end
        chk("abort done_cnt", dn, 0);
        chk("abort busy_cnt", bz, 0);
        chk("abort sum", bus8.sum, 0);
        chk("abort carry_out", bus8.carry_out, 0);
        chk("abort overflow", bus8.overflow, 0);
        run8("after_abort", 8'd200, 8'd100, 1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 20; i++)
            run8("rnd8", 8'($urandom), 8'($urandom), 1'($urandom),
                 1'($urandom), bit'($urandom));

        sweep_go = 1'b1;
        for (int i = 0; i < 60000; i++) begin
            if (g_sw[0].fin && g_sw[1].fin && g_sw[2].fin) break;
            @(negedge clk);
        end
        chk("sweep finished",
            {g_sw[0].fin, g_sw[1].fin, g_sw[2].fin}, 3'b111);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
